// File: rtl/mux_scan_pkg.sv
// rtl/mux_scan_pkg.sv - shared constants, state encoding and helpers for the mux scan controller
package mux_scan_pkg;

   localparam int NUM_CH = 32;
   localparam int SEL_W  = 5;
   localparam int CNT_W  = 4;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_SAMPLE = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   function automatic logic even_parity(input logic [NUM_CH-1:0] v);
      return ^v;
   endfunction

endpackage

// File: rtl/mux_scan_settle_timer.sv
// rtl/mux_scan_settle_timer.sv - loadable down-counter flagging the last settle cycle of a channel
module mux_scan_settle_timer
   import mux_scan_pkg::*;
#(
   parameter int W = CNT_W
)(
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         done
);

   logic [W-1:0] count;

   // Saturates at zero so a stray decrement never wraps into a long wait.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - W'(1);
      end
   end

   assign done = (count == W'(1));

endmodule

// File: rtl/mux_32_scan_ctrl.sv
// rtl/mux_32_scan_ctrl.sv - scans a 32:1 active-low-enable mux into a 32-bit snapshot word
// Optional: define MUX_SCAN_PARITY_EN to add the registered word_parity output.
module mux_32_scan_ctrl
   import mux_scan_pkg::*;
#(
   parameter int SETTLE = 1
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              continuous,
   output logic [SEL_W-1:0]  sel,
   output logic              enable,
   input  logic              mux_out,
   output logic [NUM_CH-1:0] word,
   output logic              word_valid,
`ifdef MUX_SCAN_PARITY_EN
   output logic              word_parity,
`endif
   input  logic              word_ready,
   output logic              busy
);

   localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE);
   localparam logic [1:0]       SCAN_ST   = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
   localparam logic [SEL_W-1:0] LAST_CH   = SEL_W'(NUM_CH - 1);

   logic [1:0]        state;
   // The last channel goes straight into word, so only the lower channels need storage.
   logic [NUM_CH-2:0] shreg;
   logic [NUM_CH-1:0] captured;
   logic              last_ch;
   logic              accept;
   logic              scan_start;
   logic              timer_load;
   logic              timer_done;

   assign last_ch    = (sel == LAST_CH);
   assign captured   = {mux_out, shreg};
   assign accept     = (state == ST_DONE) && word_ready;
   assign scan_start = ((state == ST_IDLE) && start) || (accept && continuous);
   assign timer_load = scan_start || ((state == ST_SAMPLE) && !last_ch);
   assign busy       = (state != ST_IDLE);

   mux_scan_settle_timer #(
      .W(CNT_W)
   ) u_settle_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (timer_load),
      .load_val (SETTLE_LD),
      .dec      (state == ST_SETTLE),
      .done     (timer_done)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         sel        <= '0;
         enable     <= 1'b1;
         word       <= '0;
         word_valid <= 1'b0;
         shreg      <= '0;
`ifdef MUX_SCAN_PARITY_EN
         word_parity <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  sel    <= '0;
                  enable <= 1'b0;
                  state  <= SCAN_ST;
               end
            end
            ST_SETTLE: begin
               if (timer_done) begin
                  state <= ST_SAMPLE;
               end
            end
            ST_SAMPLE: begin
               if (last_ch) begin
                  word       <= captured;
                  word_valid <= 1'b1;
                  enable     <= 1'b1;
                  sel        <= '0;
                  state      <= ST_DONE;
`ifdef MUX_SCAN_PARITY_EN
                  word_parity <= even_parity(captured);
`endif
               end else begin
                  shreg[sel] <= mux_out;
                  sel        <= sel + SEL_W'(1);
                  state      <= SCAN_ST;
               end
            end
            ST_DONE: begin
               if (word_ready) begin
                  word_valid <= 1'b0;
                  if (continuous) begin
                     sel    <= '0;
                     enable <= 1'b0;
                     state  <= SCAN_ST;
                  end else begin
                     state <= ST_IDLE;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mux_32_scan_ctrl.sv
// tb/tb_mux_32_scan_ctrl.sv - randomized, model-checked bench for two scan controllers (SETTLE=1 and 0)
module tb_mux_32_scan_ctrl;

   logic        clk = 1'b0;
   logic        reset, start, continuous, word_ready;
   logic [31:0] in_vec;

   logic [4:0]  sel1, sel0;
   logic        en1, en0, mo1, mo0, v1, v0, b1, b0, p1, p0;
   logic [31:0] w1, w0;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   bit chk_on  = 0;

`ifdef MUX_SCAN_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
   assign p1 = 1'b0;
   assign p0 = 1'b0;
`endif

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Active-low-enable 32:1 mux between each controller and its sample input.
   assign mo1 = en1 ? 1'b0 : in_vec[sel1];
   assign mo0 = en0 ? 1'b0 : in_vec[sel0];

   mux_32_scan_ctrl #(.SETTLE(1)) dut1 (
      .clk(clk), .reset(reset), .start(start), .continuous(continuous),
      .sel(sel1), .enable(en1), .mux_out(mo1), .word(w1), .word_valid(v1),
`ifdef MUX_SCAN_PARITY_EN
      .word_parity(p1),
`endif
      .word_ready(word_ready), .busy(b1)
   );

   mux_32_scan_ctrl #(.SETTLE(0)) dut0 (
      .clk(clk), .reset(reset), .start(start), .continuous(continuous),
      .sel(sel0), .enable(en0), .mux_out(mo0), .word(w0), .word_valid(v0),
`ifdef MUX_SCAN_PARITY_EN
      .word_parity(p0),
`endif
      .word_ready(word_ready), .busy(b0)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: a scan is a run of 32*(S+1) cycles; channel c is sampled
   // on the last cycle of its (S+1)-cycle slot, then the word is offered.
   int          m_per [2] = '{1, 2};
   bit          m_scan [2];
   bit          m_valid [2];
   int          m_k [2];
   logic [31:0] m_acc [2];
   logic [31:0] m_word [2];

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (reset) begin
            m_scan[d] = 0; m_valid[d] = 0; m_k[d] = 0; m_acc[d] = '0; m_word[d] = '0;
         end else if (m_scan[d]) begin
            if (m_k[d] % m_per[d] == m_per[d] - 1)
               m_acc[d][m_k[d] / m_per[d]] = in_vec[m_k[d] / m_per[d]];
            m_k[d]++;
            if (m_k[d] == 32 * m_per[d]) begin
               m_scan[d] = 0; m_valid[d] = 1; m_word[d] = m_acc[d];
            end
         end else if (m_valid[d]) begin
            if (word_ready) begin
               m_valid[d] = 0;
               if (continuous) begin m_scan[d] = 1; m_k[d] = 0; end
            end
         end else if (start) begin
            m_scan[d] = 1; m_k[d] = 0;
         end
      end
   end

   function automatic logic [40:0] pack(logic [4:0] s, logic e, logic b, logic v, logic [31:0] w, logic p);
      return {p, s, e, b, v, w};
   endfunction

   always @(negedge clk) begin
      if (chk_on) begin
         for (int d = 0; d < 2; d++) begin
            logic [40:0] a, e;
            a = (d == 1) ? pack(sel1, en1, b1, v1, w1, p1) : pack(sel0, en0, b0, v0, w0, p0);
            e = pack(m_scan[d] ? 5'(m_k[d] / m_per[d]) : 5'd0, !m_scan[d], m_scan[d] | m_valid[d],
                     m_valid[d], m_word[d], PAR_EN & (^m_word[d]));
            check($sformatf("cycle_dut%0d {par,sel,en,busy,valid,word}", d), 64'(a), 64'(e));
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic run_scan(input logic [31:0] v, output int lat1, output int lat0,
                           output logic [31:0] wc1, output logic [31:0] wc0);
      in_vec = v; start = 1'b1; tick(); start = 1'b0;
      lat1 = -1; lat0 = -1; wc1 = '0; wc0 = '0;
      for (int n = 1; n <= 200 && (lat1 < 0 || lat0 < 0); n++) begin
         tick();
         if (lat1 < 0 && v1) begin lat1 = n; wc1 = w1; end
         if (lat0 < 0 && v0) begin lat0 = n; wc0 = w0; end
      end
   endtask

   task automatic wait_v1(output int c);
      c = -1;
      for (int n = 0; n < 300; n++) begin
         if (v1) begin c = cyc; break; end
         tick();
      end
      check("wait_valid_timeout", 64'(c >= 0), 64'(1));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int l1, l0, c1, c2, c3, cs;
      logic [31:0] r1, r0, held, rv;

      reset = 1'b1; start = 1'b0; continuous = 1'b0; word_ready = 1'b0; in_vec = '0;
      tick(); tick();
      reset = 1'b0;
      chk_on = 1;
      check("reset_sel",   64'(sel1), 64'(0));
      check("reset_en",    64'(en1),  64'(1));
      check("reset_busy",  64'(b1),   64'(0));
      check("reset_valid", 64'(v1),   64'(0));
      check("reset_word",  64'(w0),   64'(0));

      // 1: default settle, 64-cycle latency
      word_ready = 1'b1;
      run_scan(32'hA5A5_3C3C, l1, l0, r1, r0);
      check("t1_latency",    64'(l1), 64'(64));
      check("t1_word",       64'(r1), 64'hA5A5_3C3C);
      check("t1_enable_off", 64'(en1), 64'(1));
      check("t1_model_word", 64'(m_word[1]), 64'hA5A5_3C3C);
      check("t1_s0_latency", 64'(l0), 64'(32));
      tick(); tick();

      // 2: zero settle, 32-cycle latency
      run_scan(32'h8000_0001, l1, l0, r1, r0);
      check("t2_latency", 64'(l0), 64'(32));
      check("t2_word",    64'(r0), 64'h8000_0001);
      check("t2_word_s1", 64'(r1), 64'h8000_0001);
      tick(); tick();

      // 3: backpressure holds the word; start in DONE is dropped
      word_ready = 1'b0;
      in_vec = 32'h0F0F_1234; start = 1'b1; tick(); start = 1'b0;
      wait_v1(c1);
      held = w1;
      check("t3_word", 64'(held), 64'h0F0F_1234);
      for (int n = 0; n < 10; n++) begin
         start = n[0];
         tick();
         check("t3_valid_held", 64'(v1), 64'(1));
         check("t3_word_held",  64'(w1), 64'(held));
      end
      start = 1'b0; word_ready = 1'b1;
      tick();
      check("t3_valid_drop", 64'(v1), 64'(0));
      check("t3_word_keep",  64'(w1), 64'(held));
      tick(); tick();
      check("t3_no_queued_start", 64'(b1), 64'(0));
      check("t3_no_queued_start0", 64'(b0), 64'(0));

      // 4: continuous back-to-back words, input changes during the second scan
      in_vec = 32'h1234_5678; continuous = 1'b1; start = 1'b1; tick(); start = 1'b0;
      wait_v1(c1);
      check("t4_word1", 64'(w1), 64'h1234_5678);
      tick();
      check("t4_restart_sel",  64'(sel1), 64'(0));
      check("t4_restart_en",   64'(en1),  64'(0));
      check("t4_restart_busy", 64'(b1),   64'(1));
      repeat (20) tick();
      in_vec = 32'hFFFF_0000;
      wait_v1(c2);
      check("t4_gap12", 64'(c2 - c1), 64'(65));
      tick();
      wait_v1(c3);
      check("t4_word3", 64'(w1), 64'hFFFF_0000);
      check("t4_gap23", 64'(c3 - c2), 64'(65));
      continuous = 1'b0;
      repeat (40) tick();

      // 5: reset mid-scan
      in_vec = $urandom; start = 1'b1; tick(); start = 1'b0;
      cs = -1;
      for (int n = 0; n < 100; n++) begin
         if (sel1 == 5'd17) begin cs = n; break; end
         tick();
      end
      check("t5_reach_sel17", 64'(cs >= 0), 64'(1));
      reset = 1'b1; tick(); reset = 1'b0;
      check("t5_sel",   64'(sel1), 64'(0));
      check("t5_en",    64'(en1),  64'(1));
      check("t5_busy",  64'(b1),   64'(0));
      check("t5_valid", 64'(v1),   64'(0));
      tick();
      rv = $urandom;
      run_scan(rv, l1, l0, r1, r0);
      check("t5_fresh_word",    64'(r1), 64'(rv));
      check("t5_fresh_latency", 64'(l1), 64'(64));
      tick(); tick();

`ifdef MUX_SCAN_PARITY_EN
      // 6: parity follows the word
      run_scan(32'h0000_0007, l1, l0, r1, r0);
      check("t6_parity_odd", 64'(p1), 64'(1));
      tick(); tick();
      run_scan(32'h0000_0003, l1, l0, r1, r0);
      check("t6_parity_even", 64'(p1), 64'(0));
      tick(); tick();
`endif

      // Randomized traffic, checked every cycle against the model
      for (int n = 0; n < 3000; n++) begin
         start      = ($urandom_range(0, 7) == 0);
         word_ready = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 99) == 0) continuous = ~continuous;
         if ($urandom_range(0, 39) == 0) in_vec = $urandom;
         reset      = ($urandom_range(0, 999) == 0);
         tick();
      end
      reset = 1'b0; start = 1'b0; continuous = 1'b0; word_ready = 1'b1;
      repeat (100) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
